pwm_duty_ctrl: RTL and testbench

Duty-cycle controller that sits in front of the `pwm` generator. It debounces the increment/decrement push-buttons and applies auto-repeat while a button is held. It keeps a saturating target duty and ramps the applied duty toward that target by one count per PWM period. Duty updates occur only at PWM period boundaries, so the PWM never sees a mid-period glitch.

---
 rtl/pwm_duty_ctrl_if.sv | 22 ++
 rtl/pwm_duty_ctrl.sv | 126 ++++++++++++
 tb/tb_pwm_duty_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ctrl_if.sv
// pwm_duty_ctrl_if: button, period and duty signals between the controller and its surroundings.
interface pwm_duty_ctrl_if #(
    parameter int DUTY_W = 8
);
    logic              btn_inc;
    logic              btn_dec;
    logic              period_end;
    logic [DUTY_W-1:0] duty;
    logic              duty_load;
    logic [DUTY_W-1:0] target;
    logic              busy;

    modport master (
        output btn_inc, btn_dec, period_end,
        input  duty, duty_load, target, busy
    );

    modport slave (
        input  btn_inc, btn_dec, period_end,
        output duty, duty_load, target, busy
    );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: debounced inc/dec buttons with auto-repeat set a saturating target;
// the applied duty ramps toward it by one count per PWM period boundary.
module pwm_duty_ctrl #(
    parameter int DUTY_W          = 8,
    parameter int DUTY_MAX        = 100,
    parameter int STEP            = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input logic             clk,
    input logic             rst_a_n,
    pwm_duty_ctrl_if.slave  bus
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_W = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} state_t;

    logic [1:0]        s1_q, s2_q, db_q;
    logic [DB_W-1:0]   cnt_q [2];
    state_t            state_q;
    logic              dir_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [DUTY_W-1:0] target_q, duty_q, duty_d;
    logic              duty_load_q, duty_load_d;
    logic              inc_db, dec_db, held, other;
    logic [DUTY_W:0]   sum_w;
    logic [DUTY_W-1:0] inc_t, dec_t, step_t;
    logic [TMR_W-1:0]  tmr_lim;

    assign inc_db  = db_q[0];
    assign dec_db  = db_q[1];
    assign held    = dir_q ? inc_db : dec_db;
    assign other   = dir_q ? dec_db : inc_db;
    assign sum_w   = {1'b0, target_q} + (DUTY_W+1)'(STEP);
    assign inc_t   = sum_w > (DUTY_W+1)'(DUTY_MAX) ? DUTY_W'(DUTY_MAX) : sum_w[DUTY_W-1:0];
    assign dec_t   = {1'b0, target_q} < (DUTY_W+1)'(STEP) ? '0 : target_q - DUTY_W'(STEP);
    assign step_t  = dir_q ? inc_t : dec_t;
    assign tmr_lim = state_q == HOLD ? TMR_W'(REPEAT_DELAY - 1) : TMR_W'(REPEAT_RATE - 1);

    // Index 0 is the increment button, index 1 the decrement button.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            s1_q <= {bus.btn_dec, bus.btn_inc};
            s2_q <= s1_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] != db_q[i]) begin
                    if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        db_q[i]  <= ~db_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            tmr_q    <= '0;
            target_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inc_db ^ dec_db) begin
                        target_q <= inc_db ? inc_t : dec_t;
                        dir_q    <= inc_db;
                        tmr_q    <= '0;
                        state_q  <= HOLD;
                    end else if (inc_db) begin
                        state_q <= WAIT_REL;
                    end
                end
                HOLD, REPEAT: begin
                    if (!held) begin
                        state_q <= IDLE;
                    end else if (other) begin
                        state_q <= WAIT_REL;
                    end else if (tmr_q == tmr_lim) begin
                        target_q <= step_t;
                        tmr_q    <= '0;
                        state_q  <= REPEAT;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: state_q <= (!inc_db && !dec_db) ? IDLE : WAIT_REL;
            endcase
        end
    end

    // Ramp compares against the pre-edge target, so a same-edge step applies next period.
    always_comb begin
        duty_d      = !bus.period_end ? duty_q :
                      duty_q < target_q ? duty_q + 1'b1 :
                      duty_q > target_q ? duty_q - 1'b1 : duty_q;
        duty_load_d = bus.period_end && duty_q != target_q;
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            duty_q      <= '0;
            duty_load_q <= 1'b0;
        end else begin
            duty_q      <= duty_d;
            duty_load_q <= duty_load_d;
        end
    end

    assign bus.duty      = duty_q;
    assign bus.duty_load = duty_load_q;
    assign bus.target    = target_q;
    assign bus.busy      = duty_q != target_q;
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl: directed stimulus with hand-computed expectations for pwm_duty_ctrl
// (debounce 4, repeat delay 20, repeat rate 8, period_end every 16 cycles).
module tb_pwm_duty_ctrl;
    logic       clk = 1'b0;
    logic       rst_a_n = 1'b0;
    logic       inc = 1'b0, dec = 1'b0, pe = 1'b0;
    bit         pe_en = 1'b0, mon_en = 1'b0;
    int         pe_cnt = 0, load_cnt = 0, total = 0, bad = 0;
    logic [7:0] duty_prev = '0;

    pwm_duty_ctrl_if #(.DUTY_W(8)) bus ();

    assign bus.btn_inc    = inc;
    assign bus.btn_dec    = dec;
    assign bus.period_end = pe;

    pwm_duty_ctrl #(
        .DUTY_W(8), .DUTY_MAX(100), .STEP(10),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8)
    ) dut (
        .clk(clk),
        .rst_a_n(rst_a_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int abs_diff(input int a, input int b);
        return a > b ? a - b : b - a;
    endfunction

    always @(negedge clk) begin
        pe_cnt = pe_en ? (pe_cnt + 1) % 16 : 0;
        pe = pe_en && pe_cnt == 15;
    end

    // Every duty change must come with exactly one strobe and move by one count.
    always @(negedge clk) begin
        if (mon_en && (bus.duty_load || bus.duty != duty_prev)) begin
            chk("load_strobe", int'(bus.duty_load), 1);
            chk("ramp_step", abs_diff(int'(bus.duty), int'(duty_prev)), 1);
        end
        if (bus.duty_load) load_cnt++;
        duty_prev = bus.duty;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tick(2);
        chk("rst_duty", int'(bus.duty), 0);
        chk("rst_target", int'(bus.target), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_load", int'(bus.duty_load), 0);
        rst_a_n = 1'b1;
        mon_en = 1'b1;
        tick(2);

        inc = 1'b1;
        tick(6);
        chk("press_edge6", int'(bus.target), 0);
        tick(1);
        chk("press_edge7", int'(bus.target), 10);
        chk("press_busy", int'(bus.busy), 1);
        chk("press_duty_hold", int'(bus.duty), 0);
        tick(3);
        inc = 1'b0;
        tick(20);
        load_cnt = 0;
        pe_en = 1'b1;
        tick(200);
        chk("ramp_duty", int'(bus.duty), 10);
        chk("ramp_loads", load_cnt, 10);
        chk("ramp_busy", int'(bus.busy), 0);
        chk("ramp_target", int'(bus.target), 10);

        load_cnt = 0;
        repeat (8) begin
            inc = 1'b1;
            tick(3);
            inc = 1'b0;
            tick(2);
        end
        tick(10);
        chk("bounce_target", int'(bus.target), 10);
        chk("bounce_loads", load_cnt, 0);

        inc = 1'b1;
        tick(7);
        chk("rep_first", int'(bus.target), 20);
        tick(19);
        chk("rep_before_delay", int'(bus.target), 20);
        tick(1);
        chk("rep_delay", int'(bus.target), 30);
        tick(7);
        chk("rep_before_rate", int'(bus.target), 30);
        tick(1);
        chk("rep_rate", int'(bus.target), 40);
        tick(47);
        chk("rep_90", int'(bus.target), 90);
        tick(1);
        chk("rep_100", int'(bus.target), 100);
        tick(117);
        chk("rep_sat", int'(bus.target), 100);
        inc = 1'b0;
        tick(20);
        chk("rep_after", int'(bus.target), 100);

        inc = 1'b1;
        dec = 1'b1;
        tick(15);
        chk("both_pressed", int'(bus.target), 100);
        inc = 1'b0;
        tick(15);
        chk("wait_rel", int'(bus.target), 100);
        dec = 1'b0;
        tick(15);
        dec = 1'b1;
        tick(6);
        chk("dec_edge6", int'(bus.target), 100);
        tick(1);
        chk("dec_after_both", int'(bus.target), 90);
        tick(3);
        dec = 1'b0;
        tick(20);

        dec = 1'b1;
        tick(7);
        chk("dec_first", int'(bus.target), 80);
        tick(20);
        chk("dec_delay", int'(bus.target), 70);
        tick(48);
        chk("dec_10", int'(bus.target), 10);
        tick(8);
        chk("dec_floor", int'(bus.target), 0);
        tick(37);
        chk("dec_floor_hold", int'(bus.target), 0);
        dec = 1'b0;
        tick(1700);
        chk("ramp_down_duty", int'(bus.duty), 0);
        chk("ramp_down_busy", int'(bus.busy), 0);

        repeat (5) begin
            inc = 1'b1;
            tick(10);
            inc = 1'b0;
            tick(15);
        end
        chk("five_presses", int'(bus.target), 50);
        for (int i = 0; i < 2000 && bus.duty != 8'd20; i++) tick(1);
        chk("reach_20", int'(bus.duty), 20);
        mon_en = 1'b0;
        rst_a_n = 1'b0;
        #1;
        chk("arst_duty", int'(bus.duty), 0);
        chk("arst_target", int'(bus.target), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_load", int'(bus.duty_load), 0);
        tick(3);
        rst_a_n = 1'b1;
        tick(50);
        chk("post_rst_target", int'(bus.target), 0);
        chk("post_rst_duty", int'(bus.duty), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
